// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if: 256-bit line request/response bundle between the
// data cache (master) and the line memory responder (slave).
// Optional: LINE_MEM_RANGE_CHECK_EN adds the err_o response flag.
interface line_mem_responder_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
`ifdef LINE_MEM_RANGE_CHECK_EN
  logic              err_o;
`endif

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
`ifdef LINE_MEM_RANGE_CHECK_EN
    , input err_o
`endif
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
`ifdef LINE_MEM_RANGE_CHECK_EN
    , output err_o
`endif
  );
endinterface

// File: rtl/line_mem_responder.sv
// line_mem_responder: memory end of the 256-bit line interface.
// Accepts one request at a time, waits LATENCY cycles, then performs the
// access and raises ack_o for exactly one cycle (read data on data_o, held).
// Optional: define LINE_MEM_RANGE_CHECK_EN to flag full line indices beyond
// DEPTH on err_o (write suppressed, read returns zero); otherwise they wrap.
module line_mem_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  line_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              do_access;
  logic              req_err;
  logic [IDX_W-1:0]  cap_idx;
  logic [LINE_W-1:0] cap_data;
  logic              cap_write;
  logic              cap_err;
  logic [LINE_W-1:0] data_q;
  logic [LINE_W-1:0] mem [DEPTH];

`ifdef LINE_MEM_RANGE_CHECK_EN
  // Any set bit above the storable index means the line does not exist.
  logic [ADDR_W-6:0] full_idx;
  logic              unused_addr_bits;
  assign full_idx         = bus.addr_i[ADDR_W-1:5];
  assign req_err          = (full_idx >> IDX_W) != '0;
  assign unused_addr_bits = ^bus.addr_i[4:0];
`else
  // Upper index bits are dropped so out-of-range lines alias modulo DEPTH.
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{bus.addr_i[ADDR_W-1:IDX_W+5], bus.addr_i[4:0]};
`endif

  // State and latency counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, one ACK cycle.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture: inputs are only looked at on the accepting edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cap_idx   <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
    end else if (accept) begin
      cap_idx   <= bus.addr_i[IDX_W+4:5];
      cap_data  <= bus.data_i;
      cap_write <= bus.write_i;
      cap_err   <= req_err;
    end
  end

  // Read data register: loaded only by reads, held through writes and idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else if (do_access && !cap_write) begin
      data_q <= cap_err ? '0 : mem[cap_idx];
    end
  end

  // Line storage write port.
  // NOTE: the array has no reset; contents survive rst_i and a reset during BUSY simply never reaches this edge.
  always_ff @(posedge clk_i) begin
    if (do_access && cap_write && !cap_err) begin
      mem[cap_idx] <= cap_data;
    end
  end

  assign bus.ack_o  = (state_q == ACK);
  assign bus.data_o = data_q;
`ifdef LINE_MEM_RANGE_CHECK_EN
  assign bus.err_o  = (state_q == ACK) && cap_err;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: table-driven vectors, hand-written multi-cycle
// sequences (reset abort, enable held, back-to-back) and random traffic
// checked against an associative-array line memory model.
module tb_line_mem_responder;
  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;

  typedef logic [LINE_W-1:0] line_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    line_t       wdata;
    line_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;

  line_mem_responder_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  line_mem_responder #(
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  line_t       last_rd;
  line_t       mdl [int];
  logic [31:0] written_q [$];

  task automatic check(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
    return (a >> 5) >= DEPTH;
  endfunction

  function automatic int key_of(input logic [31:0] a);
    return int'((a >> 5) % DEPTH);
  endfunction

  function automatic line_t model_read(input logic [31:0] a);
`ifdef LINE_MEM_RANGE_CHECK_EN
    if (out_of_range(a)) return '0;
`endif
    return mdl[key_of(a)];
  endfunction

  function automatic void model_write(input logic [31:0] a, input line_t d);
`ifdef LINE_MEM_RANGE_CHECK_EN
    if (out_of_range(a)) return;
`endif
    mdl[key_of(a)] = d;
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One request from IDLE; enable held through edges E1..E_hold, then dropped
  // and the other inputs scrambled. Acks are counted over a fixed window.
  task automatic transact(input logic wr, input logic [31:0] a, input line_t d,
                          input int hold, output int lat, output int nack,
                          output line_t rd, output logic err);
    lat  = -1;
    nack = 0;
    rd   = '0;
    err  = 1'b0;
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    @(posedge clk);
    for (int k = 0; k <= LATENCY + 3; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (k == hold) begin
        bus.enable_i = 1'b0;
        bus.write_i  = 1'($urandom);
        bus.addr_i   = $urandom;
        bus.data_i   = rand_line();
      end
      if (bus.ack_o === 1'b1) begin
        nack++;
        if (lat < 0) begin
          lat = k;
          rd  = bus.data_o;
`ifdef LINE_MEM_RANGE_CHECK_EN
          err = bus.err_o;
`endif
        end
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic wr, input logic [31:0] a,
                               input line_t d, input int hold, input line_t exp_rd);
    int    lat;
    int    nack;
    line_t rd;
    logic  err;
    transact(wr, a, d, hold, lat, nack, rd, err);
    check({tag, "_latency"}, 256'(lat), 256'(LATENCY));
    check({tag, "_ack_count"}, 256'(nack), 256'(1));
    if (wr) begin
      check({tag, "_data_held"}, rd, last_rd);
      model_write(a, d);
      written_q.push_back(a);
    end else begin
      check({tag, "_rdata"}, rd, exp_rd);
      last_rd = exp_rd;
    end
`ifdef LINE_MEM_RANGE_CHECK_EN
    check({tag, "_err"}, 256'(err), 256'(out_of_range(a)));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    line_t       nd, d4, a5, b5, w6, rd1, rd3;
    logic [31:0] ra;
    logic        rwr;
    int          nack;
    int          ack_at [3];
    int          n_ack6;
    int          line;

    n_checks = 0;
    n_fail   = 0;
    last_rd  = '0;

    // Reset state
    rst_n        = 1'b0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 256'(bus.ack_o), 256'(0));
    check("reset_data", bus.data_o, '0);
`ifdef LINE_MEM_RANGE_CHECK_EN
    check("reset_err", 256'(bus.err_o), 256'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: write/read pairs, low address bits ignored
    vecs[0] = '{wr: 1'b1, addr: 32'h40, wdata: {8{32'hDEADBEEF}}, exp: '0};
    vecs[1] = '{wr: 1'b0, addr: 32'h40, wdata: '0, exp: {8{32'hDEADBEEF}}};
    vecs[2] = '{wr: 1'b1, addr: 32'h80, wdata: {8{32'h1}}, exp: '0};
    vecs[3] = '{wr: 1'b0, addr: 32'h80, wdata: '0, exp: {8{32'h1}}};
    vecs[4] = '{wr: 1'b1, addr: 32'h5F, wdata: {4{64'h0123_4567_89AB_CDEF}}, exp: '0};
    vecs[5] = '{wr: 1'b0, addr: 32'h40, wdata: '0, exp: {4{64'h0123_4567_89AB_CDEF}}};
    vecs[6] = '{wr: 1'b1, addr: 32'h20, wdata: {16{16'hA5C3}}, exp: '0};
    vecs[7] = '{wr: 1'b0, addr: 32'h3F, wdata: '0, exp: {16{16'hA5C3}}};
    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, 0, vecs[i].exp);
    end

    // Enable held for two cycles after accept: no abort, ack still at LATENCY
    d4 = rand_line();
    run_and_check("hold_en_wr", 1'b1, 32'hA0, d4, 2, '0);
    run_and_check("hold_en_rd", 1'b0, 32'hA0, '0, 0, d4);

    // Reset four cycles into a write to 0x80: no ack, old line kept
    nd = rand_line();
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h80;
    bus.data_i   = nd;
    @(posedge clk);
    #1 bus.enable_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ack_in_reset", 256'(bus.ack_o), 256'(0));
    check("abort_data_cleared", bus.data_o, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    last_rd = '0;
    nack    = 0;
    for (int k = 0; k < LATENCY + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) nack++;
    end
    check("abort_no_ack", 256'(nack), 256'(0));
    check("abort_data_after_reset", bus.data_o, '0);
    run_and_check("abort_rd_old", 1'b0, 32'h80, '0, 0, {8{32'h1}});

    // Index 512 wraps onto line 0, or is rejected with err_o
    b5 = rand_line();
    a5 = rand_line();
    run_and_check("wrap_wr0", 1'b1, 32'h0, b5, 0, '0);
    run_and_check("wrap_wr512", 1'b1, 32'h4000, a5, 0, '0);
`ifdef LINE_MEM_RANGE_CHECK_EN
    run_and_check("range_rd512", 1'b0, 32'h4000, '0, 0, '0);
    run_and_check("range_rd0", 1'b0, 32'h0, '0, 0, b5);
`else
    run_and_check("wrap_rd0", 1'b0, 32'h0, '0, 0, a5);
`endif

    // Back-to-back read, write, read to 0x20 with enable held through IDLE.
    // Strobes are LATENCY+2 edges apart: LATENCY+1 idle cycles in between.
    w6     = rand_line();
    rd1    = '0;
    rd3    = '0;
    n_ack6 = 0;
    for (int i = 0; i < 3; i++) ack_at[i] = -1;
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'h20;
    bus.data_i   = '0;
    @(posedge clk);
    for (int c = 1; c <= 3 * (LATENCY + 2) + 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1 && n_ack6 < 3) begin
        ack_at[n_ack6] = c;
        if (n_ack6 == 0) begin
          rd1         = bus.data_o;
          bus.write_i = 1'b1;
          bus.data_i  = w6;
        end else if (n_ack6 == 1) begin
          bus.write_i = 1'b0;
          bus.data_i  = '0;
        end else begin
          rd3          = bus.data_o;
          bus.enable_i = 1'b0;
        end
        n_ack6++;
      end
    end
    bus.enable_i = 1'b0;
    check("b2b_ack_count", 256'(n_ack6), 256'(3));
    check("b2b_first_ack", 256'(ack_at[0]), 256'(LATENCY));
    check("b2b_gap1", 256'(ack_at[1] - ack_at[0]), 256'(LATENCY + 2));
    check("b2b_gap2", 256'(ack_at[2] - ack_at[1]), 256'(LATENCY + 2));
    check("b2b_rd1", rd1, model_read(32'h20));
    check("b2b_rd3", rd3, w6);
    model_write(32'h20, w6);
    written_q.push_back(32'h20);
    last_rd = w6;

    // Random traffic against the model
    for (int i = 0; i < 24; i++) begin
      rwr = ($urandom_range(0, 1) == 1) || (written_q.size() == 0);
      if (rwr) begin
        line = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) line += DEPTH;
        ra = 32'(line << 5) | 32'($urandom_range(0, 31));
        run_and_check($sformatf("rand%0d", i), 1'b1, ra, rand_line(),
                      $urandom_range(0, 3), '0);
      end else begin
        ra = written_q[$urandom_range(0, written_q.size() - 1)];
        ra = {ra[31:5], 5'($urandom)};
        run_and_check($sformatf("rand%0d", i), 1'b0, ra, '0,
                      $urandom_range(0, 3), model_read(ra));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
